// File: rtl/shift_pin_sin.sv
// Serial-in/parallel-out pin receiver: synchronises SCLK/SDI/SLATCH, shifts MSB first and
// publishes whole frames through a valid/ack handshake. Optional macro SHIFT_PIN_SIN_PARITY_EN.
module shift_pin_sin #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SYNC  = 2
) (
    input  logic                         i_c,
    input  logic                         i_rst_n,
    input  logic                         i_sclk,
    input  logic                         i_sdi,
    input  logic                         i_slatch,
    input  logic                         i_qack,
    output logic [WIDTH-1:0]             o_q,
    output logic                         o_qvalid,
    output logic                         o_frame_err,
    output logic                         o_overrun,
    output logic [$clog2(WIDTH+3)-1:0]   o_bitcnt
);

`ifdef SHIFT_PIN_SIN_PARITY_EN
    localparam int unsigned FL = WIDTH + 1;
`else
    localparam int unsigned FL = WIDTH;
`endif
    localparam int unsigned SRW = FL;
    localparam int unsigned CW  = $clog2(WIDTH + 3);
    localparam int unsigned AW  = $clog2(SYNC + 2);

    logic [SYNC-1:0]  r_sclk_sync;
    logic [SYNC-1:0]  r_sdi_sync;
    logic [SYNC-1:0]  r_slatch_sync;
    logic             r_sclk_prev;
    logic             r_slatch_prev;
    logic [AW-1:0]    r_arm;
    logic [SRW-1:0]   r_sr;
    logic [CW-1:0]    r_bitcnt;
    logic             r_latch_pend;
    logic [WIDTH-1:0] r_q;
    logic             r_qvalid;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_armed;
    logic             w_shift;
    logic             w_latch;
    logic             w_par_ok;
    logic             w_good;
    logic             w_bad;
    logic             w_load;
    logic [WIDTH-1:0] w_data;

    always_comb begin
        w_armed = (r_arm == AW'(SYNC + 1));
        w_shift = w_armed & r_sclk_sync[SYNC-1] & ~r_sclk_prev;
        w_latch = w_armed & r_slatch_sync[SYNC-1] & ~r_slatch_prev;
`ifdef SHIFT_PIN_SIN_PARITY_EN
        w_par_ok = ^r_sr;
`else
        w_par_ok = 1'b1;
`endif
        // Latch is judged one cycle after its edge so a coincident shift is already in sr.
        w_good = r_latch_pend & (r_bitcnt == CW'(FL)) & w_par_ok;
        w_bad  = r_latch_pend & ~((r_bitcnt == CW'(FL)) & w_par_ok);
        w_load = w_good & (~r_qvalid | i_qack);
        w_data = r_sr[SRW-1 -: WIDTH];
    end

    always_ff @(posedge i_c) begin
        if (!i_rst_n) begin
            r_sclk_sync   <= '0;
            r_sdi_sync    <= '0;
            r_slatch_sync <= '0;
            r_sclk_prev   <= 1'b0;
            r_slatch_prev <= 1'b0;
            r_arm         <= '0;
            r_sr          <= '0;
            r_bitcnt      <= '0;
            r_latch_pend  <= 1'b0;
            r_q           <= '0;
            r_qvalid      <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_sclk_sync   <= {r_sclk_sync[SYNC-2:0], i_sclk};
            r_sdi_sync    <= {r_sdi_sync[SYNC-2:0], i_sdi};
            r_slatch_sync <= {r_slatch_sync[SYNC-2:0], i_slatch};
            // History keeps loading while unarmed so a pin held high never looks like an edge.
            r_sclk_prev   <= r_sclk_sync[SYNC-1];
            r_slatch_prev <= r_slatch_sync[SYNC-1];
            if (!w_armed) begin
                r_arm <= r_arm + AW'(1);
            end
            if (w_shift) begin
                r_sr <= {r_sr[SRW-2:0], r_sdi_sync[SYNC-1]};
            end
            if (r_latch_pend) begin
                r_bitcnt <= w_shift ? CW'(1) : '0;
            end else if (w_shift && r_bitcnt != CW'(FL + 1)) begin
                r_bitcnt <= r_bitcnt + CW'(1);
            end
            r_latch_pend <= w_latch;
            r_frame_err  <= w_bad;
            if (w_load) begin
                r_q      <= w_data;
                r_qvalid <= 1'b1;
            end else if (i_qack) begin
                r_qvalid <= 1'b0;
            end
            if (w_good && r_qvalid && !i_qack) begin
                r_overrun <= 1'b1;
            end else if (i_qack && r_qvalid) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_q         = r_q;
    assign o_qvalid    = r_qvalid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_bitcnt    = r_bitcnt;

endmodule
